logic16_arbiter: RTL and testbench



---
 rtl/logic16_defs_pkg.sv | 24 ++
 rtl/logic16_unit.sv | 47 ++++
 rtl/logic16_arbiter.sv | 120 ++++++++++++
 tb/tb_logic16_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/logic16_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic16_defs (package)
// Description : Shared constants for the 16-bit logic-unit arbiter: operand
//               width, opcode values and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package logic16_defs;

   localparam int LOGIC_W = 16;

   // Opcodes for the shared bitwise logic unit
   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_XNOR = 2'b11;

   // Arbiter FSM state encodings
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

endpackage : logic16_defs
`default_nettype wire

// File: rtl/logic16_unit.sv
`default_nettype none
// ============================================================================
// Module      : logic16_unit
// Description : Purely combinational 16-bit bitwise logic unit. Builds the
//               AND/OR/XOR/XNOR planes from per-bit gate cells and picks one
//               with a 4:1 select driven by the opcode.
// Revision    : 1.0 - initial release
// ============================================================================
import logic16_defs::*;

module logic16_unit (
   input  logic [1:0]         op,
   input  logic [LOGIC_W-1:0] a,
   input  logic [LOGIC_W-1:0] b,
   output logic [LOGIC_W-1:0] y
);

   logic [LOGIC_W-1:0] w_and;
   logic [LOGIC_W-1:0] w_or;
   logic [LOGIC_W-1:0] w_xor;
   logic [LOGIC_W-1:0] w_xnor;

   // One gate cell of each kind per bit; no carries between bits
   genvar i;
   generate
      for (i = 0; i < LOGIC_W; i++) begin : g_bit
         and  u_and  (w_and[i],  a[i], b[i]);
         or   u_or   (w_or[i],   a[i], b[i]);
         xor  u_xor  (w_xor[i],  a[i], b[i]);
         xnor u_xnor (w_xnor[i], a[i], b[i]);
      end
   endgenerate

   // 4:1 result select by opcode
   always_comb begin
      y = w_and;
      case (op)
         OP_AND:  y = w_and;
         OP_OR:   y = w_or;
         OP_XOR:  y = w_xor;
         OP_XNOR: y = w_xnor;
         default: y = w_and;
      endcase
   end

endmodule : logic16_unit
`default_nettype wire

// File: rtl/logic16_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic16_arbiter
// Description : Round-robin shares one logic16_unit between two valid/ready
//               requesters. One operation in flight at a time: accept (IDLE),
//               evaluate and register (EXEC), present response (RESP).
// Revision    : 1.0 - initial release
// ============================================================================
import logic16_defs::*;

module logic16_arbiter #(
   parameter int WIDTH = 16,
   parameter int OP_W  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OP_W-1:0]  req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OP_W-1:0]  req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             busy
);

   logic [1:0]       r_state;
   logic             r_last_grant;
   logic [OP_W-1:0]  r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_id;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_id;
   logic             r_rsp_zero;

   logic             w_idle;
   logic             w_grant;
   logic             w_accept;
   logic [WIDTH-1:0] w_y;

   assign w_idle   = (r_state == S_IDLE);
   assign w_accept = w_idle & (req0_valid | req1_valid);

   // Round-robin grant: a lone requester wins; on a tie the one not served last wins
   always_comb begin
      w_grant = 1'b0;
      if (req0_valid && req1_valid) begin
         w_grant = ~r_last_grant;
      end else if (req1_valid) begin
         w_grant = 1'b1;
      end
   end

   assign req0_ready = w_idle & ~w_grant & req0_valid;
   assign req1_ready = w_idle &  w_grant & req1_valid;

   logic16_unit u_unit (
      .op (r_op),
      .a  (r_a),
      .b  (r_b),
      .y  (w_y)
   );

   // FSM, operand capture and registered response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;   // req0 wins the first tie
         r_op         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_id         <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_id     <= 1'b0;
         r_rsp_zero   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state      <= S_EXEC;
                  r_last_grant <= w_grant;
                  r_id         <= w_grant;
                  r_op         <= w_grant ? req1_op : req0_op;
                  r_a          <= w_grant ? req1_a  : req0_a;
                  r_b          <= w_grant ? req1_b  : req0_b;
               end
            end
            S_EXEC: begin
               r_state    <= S_RESP;
               r_rsp_data <= w_y;
               r_rsp_zero <= (w_y == '0);
               r_rsp_id   <= r_id;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = (r_state == S_RESP);
   assign busy      = ~w_idle;
   assign rsp_data  = r_rsp_data;
   assign rsp_id    = r_rsp_id;
   assign rsp_zero  = r_rsp_zero;

endmodule : logic16_arbiter
`default_nettype wire

// File: tb/tb_logic16_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic16_arbiter
// Description : Self-checking bench for logic16_arbiter. A behavioural model
//               tracks outstanding work by cycles since acceptance and the
//               round-robin rule; directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic16_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [1:0]  req0_op, req1_op;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
   logic [15:0] rsp_data;

   int checks = 0;
   int errors = 0;

   // Model state
   logic        m_busy;
   int          m_cyc;        // 0 = evaluating, >=1 = response presented
   logic        m_last;
   logic [15:0] m_pend_data, m_shown_data;
   logic        m_pend_id, m_shown_id, m_shown_zero;
   logic        acc0, acc1;
   logic [15:0] q_data[$];
   logic        q_id[$];

   logic16_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_cyc = 0; m_last = 1'b1;
      m_pend_data = '0; m_pend_id = 1'b0;
      m_shown_data = '0; m_shown_id = 1'b0; m_shown_zero = 1'b0;
   endtask

   // Check one cycle against the model (called at a falling edge with inputs set), then advance
   task automatic cycle();
      logic g;
      g = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
      #1;
      if (!m_busy && (req0_valid || req1_valid)) begin
         g = (req0_valid && req1_valid) ? ~m_last : req1_valid;
         acc0 = ~g; acc1 = g;
      end
      chk("req0_ready", req0_ready, acc0);
      chk("req1_ready", req1_ready, acc1);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, m_busy && m_cyc >= 1);
      chk("rsp_data", rsp_data, m_shown_data);
      chk("rsp_id", rsp_id, m_shown_id);
      chk("rsp_zero", rsp_zero, m_shown_zero);
      if (acc0 || acc1) begin
         m_busy = 1'b1; m_cyc = 0; m_last = g; m_pend_id = g;
         m_pend_data = g ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
      end else if (m_busy) begin
         if (m_cyc >= 1 && rsp_ready) begin
            m_busy = 1'b0;
            q_data.push_back(rsp_data);
            q_id.push_back(rsp_id);
         end else begin
            if (m_cyc == 0) begin
               m_shown_data = m_pend_data;
               m_shown_id   = m_pend_id;
               m_shown_zero = (m_pend_data == 16'h0000);
            end
            m_cyc++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; rsp_ready = 1'b1;
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("reset_rsp_valid", rsp_valid, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_rsp_data", rsp_data, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      // Step 1: req0 OR 0x00F0 | 0x0F00
      req0_valid = 1; req0_op = 2'd1; req0_a = 16'h00F0; req0_b = 16'h0F00;
      cycle();
      req0_valid = 0;
      cycle();
      #1;
      chk("t1_rsp_valid", rsp_valid, 1'b1);
      chk("t1_data", rsp_data, 16'h0FF0);
      chk("t1_id", rsp_id, 1'b0);
      chk("t1_zero", rsp_zero, 1'b0);
      cycle();
      cycle();

      // Step 2: req1 XNOR 0xFFFF / 0x0000
      req1_valid = 1; req1_op = 2'd3; req1_a = 16'hFFFF; req1_b = 16'h0000;
      cycle();
      req1_valid = 0;
      cycle();
      #1;
      chk("t2_data", rsp_data, 16'h0000);
      chk("t2_zero", rsp_zero, 1'b1);
      chk("t2_id", rsp_id, 1'b1);
      cycle();

      // Step 3: both valid continuously, alternating service
      q_data.delete(); q_id.delete();
      req0_valid = 1; req0_op = 2'd0; req0_a = 16'hAAAA; req0_b = 16'hFFFF;
      req1_valid = 1; req1_op = 2'd2; req1_a = 16'h1234; req1_b = 16'h1234;
      repeat (9) cycle();
      chk("t3_count", q_id.size(), 3);
      if (q_id.size() >= 3) begin
         chk("t3_id0", q_id[0], 1'b0);  chk("t3_d0", q_data[0], 16'hAAAA);
         chk("t3_id1", q_id[1], 1'b1);  chk("t3_d1", q_data[1], 16'h0000);
         chk("t3_id2", q_id[2], 1'b0);  chk("t3_d2", q_data[2], 16'hAAAA);
      end
      req0_valid = 0; req1_valid = 0;
      repeat (3) cycle();

      // Step 4: backpressure in RESP with both valids high
      req0_valid = 1; req1_valid = 1;
      cycle();                 // accept
      rsp_ready = 0;
      repeat (6) cycle();      // evaluate, then held response
      rsp_ready = 1;
      cycle();                 // handshake
      #1;
      chk("t4_accept_after", req0_ready | req1_ready, 1'b1);
      cycle();
      req0_valid = 0; req1_valid = 0;
      repeat (3) cycle();

      // Step 5: reset while req1 op is evaluating
      req0_valid = 1; req0_op = 2'd1; req0_a = 16'h5A5A; req0_b = 16'h0101;
      cycle(); req0_valid = 0;
      repeat (2) cycle();
      req1_valid = 1; req1_op = 2'd2; req1_a = 16'hF0F0; req1_b = 16'h0FF0;
      cycle();
      req1_valid = 0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rsp_valid", rsp_valid, 1'b0);
      chk("t5_busy", busy, 1'b0);
      chk("t5_rsp_data", rsp_data, 16'h0000);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cycle();
      q_id.delete(); q_data.delete();
      req0_valid = 1; req0_op = 2'd2; req0_a = 16'h00FF; req0_b = 16'h0F0F;
      req1_valid = 1; req1_op = 2'd0; req1_a = 16'hFFFF; req1_b = 16'h8001;
      #1;
      chk("t5_tie_req0", req0_ready, 1'b1);
      repeat (3) cycle();
      chk("t5_first_id", (q_id.size() > 0) ? q_id[0] : 1'bx, 1'b0);

      // Step 6: random traffic with random backpressure
      for (int n = 0; n < 300; n++) begin
         cycle();
         if (!req0_valid || acc0) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_op = 2'($urandom); req0_a = 16'($urandom); req0_b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) req0_b = req0_a;
         end
         if (!req1_valid || acc1) begin
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_op = 2'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) req1_b = ~req1_a;
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_logic16_arbiter
`default_nettype wire
